// File: rtl/ds1302_pkg.sv
// Shared definitions for the DS1302 serial bridge: FSM states, register map, default divider.
package ds1302_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_DATA,
        ST_HOLD,
        ST_GAP
    } ds_state_e;

    localparam logic [1:0] ADDR_CMD    = 2'd0;
    localparam logic [1:0] ADDR_WDATA  = 2'd1;
    localparam logic [1:0] ADDR_RDATA  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned DEFAULT_CLK_DIV = 50;

endpackage

// File: rtl/ds1302_tick.sv
// Half-period divider: one-cycle tick every CLK_DIV clocks, realigned by restart.
module ds1302_tick
    import ds1302_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (restart || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Suppressed on restart so the first half-period after a start is a full CLK_DIV.
    assign tick = !restart && (cnt_q == LAST);

endmodule

// File: rtl/ds1302_serial.sv
// Avalon-MM slave driving the DS1302 3-wire interface (CE, SCLK, bidirectional I/O).
module ds1302_serial
    import ds1302_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       csi_clk,
    input  logic       csi_reset_n,
    input  logic [1:0] avs_s1_address,
    input  logic       avs_s1_read,
    input  logic       avs_s1_write,
    input  logic [7:0] avs_s1_writedata,
    output logic [7:0] avs_s1_readdata,
    output logic       coe_clk,
    output logic       coe_reset,
    inout  wire        coe_io
);

    ds_state_e  state_q;
    logic [7:0] cmd_q, wdata_q, rdata_q, shift_q, readdata_q;
    logic [2:0] bit_q, bit_d;
    logic       gap_q, sclk_q, ce_q, oe_q, dout_q, done_q;
    logic       tick, busy, start, done_set, done_clr;

    assign busy     = (state_q != ST_IDLE);
    assign start    = avs_s1_write && (avs_s1_address == ADDR_CMD) && !busy;
    assign bit_d    = bit_q + 3'd1;
    assign done_set = (state_q == ST_GAP) && tick && gap_q;
    assign done_clr = (avs_s1_write && avs_s1_address == ADDR_CMD) ||
                      (avs_s1_read && avs_s1_address == ADDR_STATUS);

    ds1302_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (csi_clk),
        .reset_n (csi_reset_n),
        .restart (start),
        .tick    (tick)
    );

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            wdata_q <= '0;
        end else if (avs_s1_write && avs_s1_address == ADDR_WDATA) begin
            wdata_q <= avs_s1_writedata;
        end
    end

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            rdata_q <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            gap_q   <= 1'b0;
            sclk_q  <= 1'b0;
            ce_q    <= 1'b0;
            oe_q    <= 1'b0;
            dout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (done_set)      done_q <= 1'b1;
            else if (done_clr) done_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: if (start) begin
                    state_q <= ST_SETUP;
                    cmd_q   <= avs_s1_writedata;
                    ce_q    <= 1'b1;
                    sclk_q  <= 1'b0;
                    oe_q    <= 1'b1;
                    dout_q  <= avs_s1_writedata[0];
                    bit_q   <= '0;
                end
                ST_SETUP: if (tick) begin
                    state_q <= ST_CMD;
                    sclk_q  <= 1'b1;
                end
                ST_CMD: if (tick) begin
                    if (!sclk_q) begin
                        sclk_q <= 1'b1;
                    end else begin
                        sclk_q <= 1'b0;
                        if (bit_q == 3'd7) begin
                            state_q <= ST_DATA;
                            bit_q   <= '0;
                            if (cmd_q[0]) oe_q   <= 1'b0;
                            else          dout_q <= wdata_q[0];
                        end else begin
                            bit_q  <= bit_d;
                            dout_q <= cmd_q[bit_d];
                        end
                    end
                end
                ST_DATA: if (tick) begin
                    // The rising tick is the last cycle of the low phase: sample here.
                    if (!sclk_q) begin
                        sclk_q  <= 1'b1;
                        shift_q <= {coe_io, shift_q[7:1]};
                    end else begin
                        sclk_q <= 1'b0;
                        if (bit_q == 3'd7) begin
                            state_q <= ST_HOLD;
                            if (cmd_q[0]) rdata_q <= shift_q;
                        end else begin
                            bit_q  <= bit_d;
                            dout_q <= wdata_q[bit_d];
                        end
                    end
                end
                ST_HOLD: if (tick) begin
                    state_q <= ST_GAP;
                    ce_q    <= 1'b0;
                    oe_q    <= 1'b0;
                    gap_q   <= 1'b0;
                end
                ST_GAP: if (tick) begin
                    if (gap_q) state_q <= ST_IDLE;
                    else       gap_q   <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            readdata_q <= '0;
        end else if (avs_s1_read) begin
            unique case (avs_s1_address)
                ADDR_CMD:   readdata_q <= cmd_q;
                ADDR_WDATA: readdata_q <= wdata_q;
                ADDR_RDATA: readdata_q <= rdata_q;
                default:    readdata_q <= {6'b0, done_q, busy};
            endcase
        end
    end

    assign avs_s1_readdata = readdata_q;
    assign coe_clk         = sclk_q;
    assign coe_reset       = ce_q;
    assign coe_io          = oe_q ? dout_q : 1'bz;

endmodule

// File: doc/ds1302_serial.md
DS1302_SERIAL -- requirements
Module: ds1302_serial

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50: csi_clk cycles per SCLK half-period (legal range 2..255).
REQ-002 SHALL have ports:
  csi_clk  in  1  sole clock
  csi_reset_n  in  1  asynchronous, active-low reset
  avs_s1_address  in  2  register select: 0 CMD, 1 WDATA, 2 RDATA, 3 STATUS
  avs_s1_read  in  1  read strobe
  avs_s1_write  in  1  write strobe
  avs_s1_writedata  in  8  write data
  avs_s1_readdata  out  8  read data
  coe_clk  out  1  DS1302 SCLK
  coe_reset  out  1  DS1302 CE/RST, active high
  coe_io  inout  1  DS1302 I/O, driven only when the output enable is set, else high-Z

Function
REQ-003 SHALL capture WDATA on a write to address 1 at any time; the capture does not start a transfer.
REQ-004 SHALL start a transfer on a write to address 0 while idle; the byte is latched as the command and STATUS.busy reads 1 on the next cycle.
REQ-005 SHALL ignore CMD writes while busy: no latch, no restart.
REQ-006 SHALL implement states IDLE -> SETUP -> CMD -> DATA -> HOLD -> GAP -> IDLE; each state advances on a divider tick every CLK_DIV cycles.
REQ-007 SETUP SHALL: raise coe_reset with coe_clk low; drive command bit0; hold one half-period.
REQ-008 CMD SHALL shift 8 command bits LSB first; each bit is stable for a full low phase before its rising coe_clk edge.
REQ-009 If command bit0=0 (write), DATA SHALL shift the latched WDATA byte LSB first, 8 more SCLK pulses.
REQ-010 If command bit0=1 (read), SHALL release coe_io at the falling edge after the 8th command pulse, then generate 8 pulses.
REQ-011 In a read, SHALL sample coe_io in the last csi_clk cycle of each low phase, before each of the 8 data rising edges; bits are assembled LSB first.
REQ-012 In a read, SHALL update RDATA once, on entry to HOLD; RDATA holds its value until the next read completes.
REQ-013 Each transfer SHALL produce exactly 16 rising coe_clk edges.
REQ-014 HOLD SHALL keep coe_clk low and coe_reset high for one half-period, then drop coe_reset and release coe_io.
REQ-015 GAP SHALL keep coe_reset low for 2 half-periods before IDLE, giving CE inactive time.
REQ-016 STATUS readdata SHALL be {6'b0, done, busy}; busy=1 outside IDLE; done is set on GAP->IDLE and cleared by a CMD write or a STATUS read.
REQ-017 If a STATUS read coincides with done being set, done SHALL remain set (set wins).
REQ-018 avs_s1_readdata SHALL be registered, valid the cycle after avs_s1_read; addresses 0 and 1 read back the latched command and WDATA.
REQ-019 The divider SHALL reset to 0 on each transfer start, so the first half-period is exactly CLK_DIV cycles.

Reset
REQ-020 On csi_reset_n low, SHALL immediately set: coe_clk=0, coe_reset=0, coe_io released, state IDLE, all registers 0x00, busy=0, done=0.
REQ-021 Reset mid-transfer SHALL abort without completing; no RDATA update, no done.

Structure
REQ-022 Package ds1302_pkg SHALL hold the state enumeration, the register address constants, and the default CLK_DIV.
REQ-023 Sub-module ds1302_tick SHALL implement the half-period divider: inputs clk, reset_n, restart; output one-cycle tick.

Verification
REQ-024 Write command: CLK_DIV=4, WDATA=0x25, CMD=0x80 -> coe_io at 16 rising edges reads 0,0,0,0,0,0,0,1,1,0,1,0,0,1,0,0; coe_reset high throughout; done=1 at end.
REQ-025 Read command: CMD=0x81, DS1302 model drives 0x59 -> RDATA=0x59; coe_io high-Z from the falling edge after the 8th pulse until the next SETUP.
REQ-026 Busy lockout: CMD=0x80, then CMD=0x82 issued while busy -> single transfer carrying 0x80, exactly 16 edges.
REQ-027 Reset abort: csi_reset_n pulsed low after the 5th rising edge -> coe_reset and coe_clk 0 the same cycle, STATUS=0x00, RDATA unchanged.
REQ-028 Minimum divider: CLK_DIV=2 -> every coe_clk half-period is exactly 2 cycles; done/STATUS read race per REQ-017 leaves done=1.
